// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - Q103H load/store data-memory access controller with ack timeout
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_req_Q103H,
  input  logic                st_req_Q103H,
  input  logic [ADDR_W-1:0]   addr_Q103H,
  input  logic [DATA_W-1:0]   wdata_Q103H,
  input  logic [DATA_W/8-1:0] be_Q103H,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_be,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                stall_Q103H,
  output logic [DATA_W-1:0]   rd_data_Q103H,
  output logic                rd_valid_Q103H,
  output logic                err_timeout
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        count_inc;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [BE_W-1:0]   dmem_be_q, dmem_be_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_timeout_q, err_timeout_d;
  logic              req_any;

  assign req_any   = ld_req_Q103H | st_req_Q103H;
  // count_q holds completed BUSY cycles, so the current BUSY cycle number is count_q + 1
  assign count_inc = count_q + 8'd1;

  // Next-state and registered-output computation; a store wins when both requests are present
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    dmem_be_d     = dmem_be_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      IDLE: begin
        rd_valid_d = 1'b0;
        if (req_any) begin
          state_d      = BUSY;
          count_d      = 8'd0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = st_req_Q103H;
          dmem_addr_d  = addr_Q103H;
          dmem_wdata_d = wdata_Q103H;
          dmem_be_d    = be_Q103H;
        end
      end
      BUSY: begin
        count_d = count_inc;
        if (dmem_ack) begin
          // ack beats the timeout even on the final allowed cycle
          state_d    = DONE;
          dmem_req_d = 1'b0;
          rd_valid_d = ~dmem_we_q;
          if (!dmem_we_q) rd_data_d = dmem_rdata;
        end else if (count_inc == TIMEOUT_C) begin
          state_d       = DONE;
          dmem_req_d    = 1'b0;
          err_timeout_d = 1'b1;
          rd_valid_d    = ~dmem_we_q;
          if (!dmem_we_q) rd_data_d = '0;
        end
      end
      DONE: begin
        state_d    = IDLE;
        rd_valid_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
        rd_valid_d = 1'b0;
      end
    endcase
  end

  // Single state register for the FSM and all of its registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= 8'd0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_be_q     <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      dmem_be_q     <= dmem_be_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Stall is combinational so the requesting instruction freezes in its own cycle
  always_comb begin
    stall_Q103H = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    stall_Q103H = req_any;
        BUSY:    stall_Q103H = 1'b1;
        default: stall_Q103H = 1'b0;
      endcase
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_be        = dmem_be_q;
  assign rd_data_Q103H  = rd_data_q;
  assign rd_valid_Q103H = rd_valid_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - table-driven scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        ld_req_Q103H;
  logic        st_req_Q103H;
  logic [31:0] addr_Q103H;
  logic [31:0] wdata_Q103H;
  logic [3:0]  be_Q103H;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_Q103H;
  logic [31:0] rd_data_Q103H;
  logic        rd_valid_Q103H;
  logic        err_timeout;

  int checks;
  int failures;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_at;   // BUSY cycle on which ack is driven, 0 = never
    logic [31:0] rdata;
    int          exp_busy;
    logic        exp_we;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_to;
  } rec_t;

  rec_t tbl[7];
  rec_t sb_q[$];
  rec_t extra_r;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_req_Q103H   (ld_req_Q103H),
    .st_req_Q103H   (st_req_Q103H),
    .addr_Q103H     (addr_Q103H),
    .wdata_Q103H    (wdata_Q103H),
    .be_Q103H       (be_Q103H),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .stall_Q103H    (stall_Q103H),
    .rd_data_Q103H  (rd_data_Q103H),
    .rd_valid_Q103H (rd_valid_Q103H),
    .err_timeout    (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One full access: request cycle, BUSY cycles with a scripted ack, result checked in DONE
  task automatic run_access(input rec_t r);
    rec_t e;
    int   busy;
    @(negedge clk);
    ld_req_Q103H = r.ld;
    st_req_Q103H = r.st;
    addr_Q103H   = r.addr;
    wdata_Q103H  = r.wdata;
    be_Q103H     = r.be;
    sb_q.push_back(r);
    #1;
    chk("req_cycle_stall", {31'd0, stall_Q103H}, 32'd1);
    chk("req_cycle_dmem_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    ld_req_Q103H = 1'b0;
    st_req_Q103H = 1'b0;
    addr_Q103H   = ~r.addr;
    wdata_Q103H  = ~r.wdata;
    be_Q103H     = ~r.be;
    busy = 0;
    while (stall_Q103H && busy < 300) begin
      busy++;
      chk("busy_req", {31'd0, dmem_req}, 32'd1);
      chk("busy_addr", dmem_addr, r.addr);
      chk("busy_wdata", dmem_wdata, r.wdata);
      chk("busy_be", {28'd0, dmem_be}, {28'd0, r.be});
      chk("busy_we", {31'd0, dmem_we}, {31'd0, r.exp_we});
      if (busy == r.ack_at) begin
        dmem_ack   = 1'b1;
        dmem_rdata = r.rdata;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("busy_cycles", busy, e.exp_busy);
      chk("done_stall", {31'd0, stall_Q103H}, 32'd0);
      chk("done_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("done_rd_valid", {31'd0, rd_valid_Q103H}, {31'd0, e.exp_rv});
      chk("done_rd_data", rd_data_Q103H, e.exp_rd);
      chk("done_err_timeout", {31'd0, err_timeout}, {31'd0, e.exp_to});
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    ld_req_Q103H = 1'b1;
    st_req_Q103H = 1'b0;
    addr_Q103H   = 32'h0;
    wdata_Q103H  = 32'h0;
    be_Q103H     = 4'h0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;

    //         ld    st    addr       wdata         be    ack rdata         busy we    rv    exp_rd        to
    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'hF, 1,  32'hDEADBEEF, 1,  1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h204, 32'h12345678, 4'hF, 3,  32'h99999999, 3,  1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h300, 32'h0,        4'hF, 16, 32'hCAFEF00D, 16, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h40C, 32'hA5A5A5A5, 4'h3, 2,  32'h77777777, 2,  1'b1, 1'b0, 32'hCAFEF00D, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h500, 32'h0,        4'hF, 0,  32'h0,        16, 1'b0, 1'b1, 32'h0,        1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h600, 32'h0,        4'hF, 1,  32'h11223344, 1,  1'b0, 1'b1, 32'h11223344, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h700, 32'hFEEDFACE, 4'hC, 0,  32'h0,        16, 1'b1, 1'b0, 32'h11223344, 1'b1};

    // reset state, with a request held high
    @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall_Q103H}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid_Q103H}, 32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    ld_req_Q103H = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_access(tbl[i]);

    // request presented during DONE is ignored, then seen combinationally in IDLE
    ld_req_Q103H = 1'b1;
    addr_Q103H   = 32'hBAD;
    #1;
    chk("done_ignores_req", {31'd0, stall_Q103H}, 32'd0);
    @(negedge clk);
    #1;
    chk("idle_req_stall", {31'd0, stall_Q103H}, 32'd1);
    ld_req_Q103H = 1'b0;
    #1;
    chk("idle_noreq_stall", {31'd0, stall_Q103H}, 32'd0);

    // stray ack in IDLE
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_ack_stall", {31'd0, stall_Q103H}, 32'd0);
    chk("stray_ack_rv", {31'd0, rd_valid_Q103H}, 32'd0);
    chk("stray_ack_rd", rd_data_Q103H, 32'h11223344);

    extra_r = '{1'b1, 1'b0, 32'h800, 32'h0, 4'hF, 1, 32'h55AA55AA, 1, 1'b0, 1'b1, 32'h55AA55AA, 1'b1};
    run_access(extra_r);

    // reset in the middle of BUSY
    @(negedge clk);
    ld_req_Q103H = 1'b1;
    addr_Q103H   = 32'hA00;
    @(negedge clk);
    ld_req_Q103H = 1'b0;
    chk("pre_rst_busy_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    rst          = 1'b1;
    ld_req_Q103H = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_Q103H}, 32'd0);
    chk("mid_rst_addr", dmem_addr, 32'd0);
    chk("mid_rst_rd", rd_data_Q103H, 32'd0);
    chk("mid_rst_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    ld_req_Q103H = 1'b0;
    rst          = 1'b0;
    #1;
    chk("post_rst_idle_req", {31'd0, dmem_req}, 32'd0);

    extra_r = '{1'b1, 1'b0, 32'h900, 32'h0, 4'h1, 2, 32'h0BADF00D, 2, 1'b0, 1'b1, 32'h0BADF00D, 1'b0};
    run_access(extra_r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, data-memory word width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max BUSY cycles awaiting dmem_ack (legal 2..255).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port ld_req_Q103H  in  1  load instruction valid in Q103H.
REQ-007 SHALL have port st_req_Q103H  in  1  store instruction valid in Q103H.
REQ-008 SHALL have port addr_Q103H  in  ADDR_W  ALU-computed address.
REQ-009 SHALL have port wdata_Q103H  in  DATA_W  store data.
REQ-010 SHALL have port be_Q103H  in  DATA_W/8  byte enables.
REQ-011 SHALL have ports dmem_req / dmem_we  out  1 / 1  memory request, write strobe.
REQ-012 SHALL have ports dmem_addr / dmem_wdata / dmem_be  out  ADDR_W / DATA_W / DATA_W/8  registered request fields.
REQ-013 SHALL have ports dmem_ack / dmem_rdata  in  1 / DATA_W  completion, read data (valid with ack).
REQ-014 SHALL have port stall_Q103H  out  1  freezes Q103H and all older stages.
REQ-015 SHALL have ports rd_data_Q103H / rd_valid_Q103H  out  DATA_W / 1  load result and its qualifier.
REQ-016 SHALL have port err_timeout  out  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-018 IDLE with ld_req_Q103H or st_req_Q103H: SHALL assert stall_Q103H combinationally that cycle, latch addr/wdata/be, set we=st_req, go BUSY.
REQ-019 Both ld and st asserted SHALL be treated as a store.
REQ-020 IDLE with no request: stall_Q103H=0, dmem_req=0, stay IDLE.
REQ-021 BUSY: dmem_req=1, stall_Q103H=1; dmem_addr/wdata/be/we SHALL stay constant until leaving BUSY.
REQ-022 BUSY with dmem_ack: SHALL register dmem_rdata into rd_data_Q103H (loads only; stores leave it unchanged), go DONE.
REQ-023 BUSY SHALL count cycles from 1; count reaching TIMEOUT without ack SHALL set err_timeout, force rd_data_Q103H=0 for a load, go DONE.
REQ-024 Ack on the cycle count reaches TIMEOUT: ack SHALL win, err_timeout unchanged.
REQ-025 DONE: stall_Q103H=0, dmem_req=0, rd_valid_Q103H=1 iff latched op is a load; SHALL ignore request inputs; next state IDLE.
REQ-026 dmem_ack outside BUSY SHALL be ignored.
REQ-027 Minimum access latency: request cycle + 1 BUSY cycle + DONE = stall for 2 cycles when ack arrives on first BUSY cycle.
REQ-028 err_timeout SHALL remain 1 until reset.
REQ-029 Count register width SHALL be 8 bits, cleared on BUSY entry; no wrap possible.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, dmem_req=0, dmem_we=0, dmem_addr/wdata/be=0, rd_data_Q103H=0, rd_valid_Q103H=0, err_timeout=0, count=0.
REQ-031 stall_Q103H SHALL be 0 while rst=1 regardless of request inputs.
REQ-032 Reset asserted in BUSY SHALL abandon the access; first cycle after release behaves as IDLE.

Verification
REQ-033 Load addr 0x100, ack on 1st BUSY cycle with rdata 0xDEADBEEF -> stall 2 cycles, DONE rd_valid=1, rd_data=0xDEADBEEF.
REQ-034 Store addr 0x204 wdata 0x12345678 be 0xF, ack after 3 BUSY cycles -> dmem_we=1, fields stable 3 cycles, rd_valid=0 in DONE.
REQ-035 Load, no ack (TIMEOUT=16) -> dmem_req high 16 cycles, then err_timeout=1, rd_data=0, rd_valid=1; flag persists across later accesses.
REQ-036 Ack exactly on 16th BUSY cycle -> DONE with captured data, err_timeout=0.
REQ-037 rst asserted mid-BUSY -> dmem_req=0 same cycle, all outputs reset; new load after release completes normally.
REQ-038 Back-to-back loads (new ld_req in DONE-following cycle), stray ack in IDLE, ld+st together -> second access starts from IDLE, stray ack ignored, simultaneous request issues as store.
